// File: rtl/sprite_draw_queue.sv
// First-word-fall-through sprite entry queue between the host and the sprite renderer.
// Optional SPRITE_QUEUE_STATS_EN adds drop_count and high_water statistics outputs.
module sprite_draw_queue #(
    parameter int DEPTH = 32
) (
    input  logic                      clock,
    input  logic                      fb_resetting,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [7:0]                enq_id,
    input  logic [15:0]               enq_x,
    input  logic [15:0]               enq_y,
    input  logic [7:0]                enq_scale,
    input  logic                      sprite_queue_dequeue,
    output logic                      sprite_queue_is_empty,
    output logic [7:0]                sprite_queue_sprite_id,
    output logic [15:0]               sprite_queue_sprite_x,
    output logic [15:0]               sprite_queue_sprite_y,
    output logic [7:0]                sprite_queue_sprite_scale,
`ifdef SPRITE_QUEUE_STATS_EN
    output logic [15:0]               drop_count,
    output logic [$clog2(DEPTH):0]    high_water,
`endif
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [47:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [47:0]   head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign enq_ready             = !full;
    assign sprite_queue_is_empty = empty;

    assign push = enq_valid && !full;
    assign pop  = sprite_queue_dequeue && !empty;

    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push && !fb_resetting) mem[wr_ptr[AW-1:0]] <= {enq_id, enq_x, enq_y, enq_scale};
    end

    assign head                      = mem[rd_ptr[AW-1:0]];
    assign sprite_queue_sprite_id    = head[47:40];
    assign sprite_queue_sprite_x     = head[39:24];
    assign sprite_queue_sprite_y     = head[23:8];
    assign sprite_queue_sprite_scale = head[7:0];

`ifdef SPRITE_QUEUE_STATS_EN
    logic [PW-1:0] count_next;

    assign count_next = count + PW'(push) - PW'(pop);

    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            drop_count <= '0;
            high_water <= '0;
        end else begin
            if (enq_valid && full && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
            if (count_next > high_water) high_water <= count_next;
        end
    end
`endif

endmodule

// File: doc/sprite_draw_queue.md
SPRITE_DRAW_QUEUE -- requirements
Module: sprite_draw_queue

Interface
REQ-001 Parameter DEPTH, 32, number of queue entries; power of two, 2..256.
REQ-002 Port clock  in  1  system clock; all state changes on its rising edge.
REQ-003 Port fb_resetting  in  1  reset, asynchronous, active-high; flushes the queue.
REQ-004 Port enq_valid  in  1  host offers one sprite entry this cycle.
REQ-005 Port enq_ready  out  1  queue accepts the offered entry; high when not full.
REQ-006 Port enq_id  in  8  sprite id to enqueue.
REQ-007 Port enq_x, enq_y  in  16 each  sprite screen position to enqueue.
REQ-008 Port enq_scale  in  8  sprite scale to enqueue.
REQ-009 Port sprite_queue_dequeue  in  1  consumer pops the head entry.
REQ-010 Port sprite_queue_is_empty  out  1  no entry available.
REQ-011 Port sprite_queue_sprite_id  out  8  head entry id.
REQ-012 Port sprite_queue_sprite_x, sprite_queue_sprite_y  out  16 each  head entry position.
REQ-013 Port sprite_queue_sprite_scale  out  8  head entry scale.
REQ-014 Port count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 The queue SHALL be first-word-fall-through: head fields show the oldest entry whenever sprite_queue_is_empty is low, with no read latency.
REQ-016 An enqueue SHALL occur on a rising edge where enq_valid && enq_ready; the entry is visible at the head no earlier than the following cycle.
REQ-017 A pop SHALL occur on a rising edge where sprite_queue_dequeue && !sprite_queue_is_empty; head fields and is_empty reflect the next entry in the following cycle.
REQ-018 A dequeue while empty SHALL be ignored with no state change.
REQ-019 Simultaneous enqueue and pop SHALL leave count unchanged and keep FIFO order; when full, a same-cycle pop does not raise enq_ready (enq_ready depends on count only).
REQ-020 enq_ready SHALL equal (count != DEPTH); enq_valid while full SHALL drop the offer with no state change.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty SHALL be derived from pointer MSB and index comparison.
REQ-022 Head fields SHALL hold the last valid entry's values or any value while empty; consumers only sample them when is_empty is low.
REQ-023 Entry storage SHALL be 48 bits wide (id, x, y, scale) and SHALL not be cleared by reset.

Reset
REQ-024 While fb_resetting is high: pointers = 0, count = 0, sprite_queue_is_empty = 1, enq_ready = 1, and enqueue/dequeue are ignored.
REQ-025 Assertion mid-operation SHALL discard all entries immediately (asynchronously); the first enqueue is accepted on the first rising edge after deassertion.

Configuration
REQ-026 Macro SPRITE_QUEUE_STATS_EN SHALL, when defined, add outputs drop_count (16, counts enq_valid while full, saturating at 16'hFFFF) and high_water ($clog2(DEPTH)+1, maximum count since reset); both reset to 0 by fb_resetting.
REQ-027 Without SPRITE_QUEUE_STATS_EN, those ports and their logic SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then enqueue id=5,x=100,y=200,scale=16 -> next cycle is_empty=0, head=(5,100,200,16), count=1.
REQ-029 DEPTH=4: enqueue 5 entries back-to-back -> enq_ready low after the 4th, 5th dropped, count=4, pops return entries 1..4 in order, then is_empty=1 (drop_count=1 with STATS_EN).
REQ-030 Consumer pattern: dequeue pulsed one cycle, low one cycle, repeated on a full queue of 8 -> all 8 entries popped in order in 16 cycles, no entry skipped or duplicated.
REQ-031 Count=2, enqueue and dequeue on the same edge -> count stays 2, head advances to the 2nd entry, new entry appears after it.
REQ-032 Queue holding 3 entries, assert fb_resetting for one half-cycle between edges -> is_empty=1 and count=0 immediately; stale entries never appear.
REQ-033 Run 3*DEPTH enqueue/pop pairs -> pointer wrap produces correct order, is_empty/full never falsely asserted.
